vga_fb_scaler: RTL and testbench
================================

Name: vga_fb_scaler

Overview:
- Read-side address generator and pixel formatter between the dual-port frame buffer and the 640x480 VGA driver, running in the 25 MHz VGA domain.
- Maps VGA raster position to a frame-buffer address for a CAM_W x CAM_H image placed at offset (X0,Y0).
- Supports 1x/2x/4x integer upscaling, using incremental counters instead of a multiplier.
- Drives BORDER_COLOR outside the image window and aligns pixel output with the buffer's one-cycle read latency.

Parameters:
- AW, 15, frame-buffer address width.
- DW, 8, pixel width (RGB332).
- CAM_W, 176, stored image width in pixels.
- CAM_H, 144, stored image height in lines.
- X0, 0, horizontal window offset in VGA pixels.
- Y0, 0, vertical window offset in VGA lines.
- SCREEN_X, 640, visible VGA width.
- SCREEN_Y, 480, visible VGA height.
- BORDER_COLOR, 8'h00, pixel value outside the window.

Ports:
- clk  in  1  25 MHz VGA pixel clock.
- rst  in  1  asynchronous reset, active-low.
- mode  in  2  scale select: 0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x).
- pos_x  in  10  next-pixel X from the VGA driver; raster order, 0..799.
- pos_y  in  9  next-pixel Y from the VGA driver; raster order.
- mem_addr  out  AW  frame-buffer read address.
- mem_data  in  DW  frame-buffer read data, valid one clk after mem_addr.
- pixel_out  out  DW  pixel to the VGA driver pixelIn.
- in_window  out  1  high when pixel_out carries image data; aligned with pixel_out.
- frame_start  out  1  one-cycle pulse when pos=(0,0) is sampled.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_addr=0, pixel_out=0, in_window=0, frame_start=0.
  - Latched scale S=1; all counters 0.
- Scale latch:
  - mode is sampled only on the edge where pos_x=0 and pos_y=0; frame_start pulses on that same edge.
  - A mid-frame change of mode takes no effect until the next (0,0).
- Window:
  - W = min(CAM_W*S, SCREEN_X-X0); H = min(CAM_H*S, SCREEN_Y-Y0).
  - win = X0 <= pos_x < X0+W and Y0 <= pos_y < Y0+H.
  - Clipped image pixels are never addressed.
- Counters (clk edge, registered):
  - Horizontal: col (AW bits), rx (0..S-1).
  - Vertical: row_base (AW bits), ry (0..S-1).
- Line start (pos_x=0):
  - pos_y=Y0: row_base=0, ry=0.
  - Y0 < pos_y < Y0+H: ry+1; when ry wraps from S-1 to 0, row_base += CAM_W.
- Column (within a line):
  - pos_x=X0: col=0, rx=0.
  - Each further in-window pixel: rx+1; on wrap from S-1, col+1.
- Address:
  - mem_addr register loads row_base+col (combinationally from next-state counters) when win=1.
  - mem_addr holds its previous value when win=0.
  - Address sequence is guaranteed for raster-order pos only; non-raster stimulus is undefined.
- Pipeline (pos sampled at edge n):
  - mem_addr updates at edge n+1.
  - mem_data is valid during cycle n+1..n+2.
  - pixel_out and in_window update at edge n+2: pixel_out = win_d ? mem_data : BORDER_COLOR, where win_d is win delayed 1 cycle.
  - Fixed latency: 2 clk from pos to pixel_out.
- Arithmetic:
  - All addresses are AW-bit unsigned.
  - CAM_W*CAM_H must be <= 2^AW; max address is CAM_W*CAM_H-1 (25343 at defaults), with no wrap within a frame.
- Boundaries:
  - Last image pixel, 1x: (175,143) -> addr 25343.
  - Pixel at X0+W: border.
  - 4x at defaults: W=640 (clipped from 704), H=480 (clipped from 576); last visible row index 119.
- Reset mid-frame: outputs return to reset values immediately; addressing resumes correctly from the next (0,0) after release.

Test Plan:
- 1x, defaults, full raster sweep: pos (5,2) -> mem_addr=357 one edge later; pixel_out=mem_data two edges later; in_window=1.
- 2x latched at (0,0): pos (5,2) -> mem_addr=178 (row 1, col 2); pos (351,287) -> 25343; pos (352,0) -> pixel_out=8'h00, in_window=0, mem_addr held.
- 4x: pos (639,479) -> mem_addr=119*176+159=21103; pos (640,0) -> border. Mode=3 -> behaves as 1x, e.g. (5,2) -> 357.
- mode changed 0->1 at pos (100,50): addressing stays 1x until the next (0,0) (frame_start=1), then 2x.
- X0=64, Y0=16, 1x: pos (64,16) -> addr 0; (63,16) -> border; (239,159) -> 25343; (240,159) -> border.
- rst=0 asserted at pos (200,100) for 3 clks -> all outputs 0 asynchronously; after release and the next (0,0), pos (5,2) -> 357.

Source files
------------

// File: rtl/vga_fb_scaler.sv
// Purpose : read-side frame-buffer address generator and pixel formatter for a 640x480 VGA raster,
//           placing a CAM_W x CAM_H image at (X0,Y0) with 1x/2x/4x integer upscaling.
// Latency : fixed 2 clk from pos_x/pos_y to pixel_out/in_window (mem_addr after 1 clk).
// Backpressure: none; the raster is free-running, so every cycle produces one pixel.
//
// Ports:
//   clk, rst        pixel clock; asynchronous active-low reset
//   mode            scale select (0=1x, 1=2x, 2=4x, 3=1x), latched at raster (0,0)
//   pos_x, pos_y    next-pixel raster position from the VGA driver
//   mem_addr        frame-buffer read address (registered)
//   mem_data        frame-buffer read data, valid the cycle after mem_addr
//   pixel_out       image pixel or BORDER_COLOR
//   in_window       pixel_out carries image data
//   frame_start     one-cycle pulse after (0,0) is sampled
module vga_fb_scaler #(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int CAM_W    = 176,
  parameter int CAM_H    = 144,
  parameter int X0       = 0,
  parameter int Y0       = 0,
  parameter int SCREEN_X = 640,
  parameter int SCREEN_Y = 480,
  parameter logic [DW-1:0] BORDER_COLOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [9:0]    pos_x,
  input  logic [8:0]    pos_y,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] pixel_out,
  output logic          in_window,
  output logic          frame_start
);

  localparam int XROOM = SCREEN_X - X0;
  localparam int YROOM = SCREEN_Y - Y0;

  // Scale is held as a shift amount: 0=1x, 1=2x, 2=4x.
  logic [1:0]    sh_q, sh_d;
  logic [AW-1:0] col_q, col_d;
  logic [1:0]    rx_q, rx_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [1:0]    ry_q, ry_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          win_q, win_d;
  logic [DW-1:0] pixel_out_q, pixel_out_d;
  logic          in_window_q, in_window_d;
  logic          frame_start_q, frame_start_d;

  logic [15:0] px, py;
  logic [15:0] img_w, img_h, win_w, win_h;
  logic [1:0]  smax;
  logic        frame_origin, x_in, y_in, win;

  assign px           = 16'(pos_x);
  assign py           = 16'(pos_y);
  assign frame_origin = (pos_x == '0) && (pos_y == '0);

  always_comb begin
    sh_d = sh_q;
    if (frame_origin) begin
      case (mode)
        2'd1:    sh_d = 2'd1;
        2'd2:    sh_d = 2'd2;
        default: sh_d = 2'd0;
      endcase
    end

    case (sh_d)
      2'd0:    smax = 2'd0;
      2'd1:    smax = 2'd1;
      default: smax = 2'd3;
    endcase

    // Upscaled image size, clipped to the screen area right of / below the offset.
    img_w = 16'(CAM_W) << sh_d;
    img_h = 16'(CAM_H) << sh_d;
    win_w = (img_w > 16'(XROOM)) ? 16'(XROOM) : img_w;
    win_h = (img_h > 16'(YROOM)) ? 16'(YROOM) : img_h;

    x_in = (px >= 16'(X0)) && (px < 16'(X0) + win_w);
    y_in = (py >= 16'(Y0)) && (py < 16'(Y0) + win_h);
    win  = x_in && y_in;
  end

  always_comb begin
    row_base_d = row_base_q;
    ry_d       = ry_q;
    col_d      = col_q;
    rx_d       = rx_q;

    // Vertical counters advance once per line, at its first raster position.
    if (pos_x == '0) begin
      if (py == 16'(Y0)) begin
        row_base_d = '0;
        ry_d       = '0;
      end else if (y_in) begin
        if (ry_q == smax) begin
          ry_d       = '0;
          row_base_d = row_base_q + AW'(CAM_W);
        end else begin
          ry_d = ry_q + 2'd1;
        end
      end
    end

    if (px == 16'(X0)) begin
      col_d = '0;
      rx_d  = '0;
    end else if (win) begin
      if (rx_q == smax) begin
        rx_d  = '0;
        col_d = col_q + AW'(1);
      end else begin
        rx_d = rx_q + 2'd1;
      end
    end

    // Address comes from next-state counters so it lands one edge after pos.
    mem_addr_d    = win ? (row_base_d + col_d) : mem_addr_q;
    win_d         = win;
    pixel_out_d   = win_q ? mem_data : BORDER_COLOR;
    in_window_d   = win_q;
    frame_start_d = frame_origin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q          <= '0;
      col_q         <= '0;
      rx_q          <= '0;
      row_base_q    <= '0;
      ry_q          <= '0;
      mem_addr_q    <= '0;
      win_q         <= 1'b0;
      pixel_out_q   <= '0;
      in_window_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      sh_q          <= sh_d;
      col_q         <= col_d;
      rx_q          <= rx_d;
      row_base_q    <= row_base_d;
      ry_q          <= ry_d;
      mem_addr_q    <= mem_addr_d;
      win_q         <= win_d;
      pixel_out_q   <= pixel_out_d;
      in_window_q   <= in_window_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign pixel_out   = pixel_out_q;
  assign in_window   = in_window_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Purpose : directed bench for vga_fb_scaler; one instance at default placement,
//           one at offset (64,16), both fed by the same raster stream.
// Latency : checks mem_addr one clk and pixel_out/in_window two clk after each probed pos.
// Backpressure: none.
module tb_vga_fb_scaler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [9:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;

  logic [14:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_data1, mem_data2;
  logic [7:0]  pixel_out1, pixel_out2;
  logic        in_window1, in_window2;
  logic        frame_start1, frame_start2;

  int checks = 0;
  int errs   = 0;

  always #20 clk = ~clk;

  // Frame-buffer model: data is a fixed function of the presented address.
  function automatic logic [7:0] pix_fn(input int a);
    return 8'(a ^ (a >> 7));
  endfunction

  assign mem_data1 = pix_fn(int'(mem_addr1));
  assign mem_data2 = pix_fn(int'(mem_addr2));

  vga_fb_scaler u_dut (
    .clk(clk), .rst(rst), .mode(mode), .pos_x(pos_x), .pos_y(pos_y),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .pixel_out(pixel_out1),
    .in_window(in_window1), .frame_start(frame_start1)
  );

  vga_fb_scaler #(.X0(64), .Y0(16)) u_dut_ofs (
    .clk(clk), .rst(rst), .mode(mode), .pos_x(pos_x), .pos_y(pos_y),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .pixel_out(pixel_out2),
    .in_window(in_window2), .frame_start(frame_start2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one raster position for exactly one clock (drive at negedge).
  task automatic visit(input int x, input int y);
    pos_x = 10'(x);
    pos_y = 9'(y);
    @(negedge clk);
  endtask

  task automatic lines(input int y_from, input int y_to);
    for (int y = y_from; y <= y_to; y++) visit(0, y);
  endtask

  task automatic sweep(input int y, input int x_from, input int x_to);
    for (int x = x_from; x <= x_to; x++) visit(x, y);
  endtask

  task automatic new_frame(input logic [1:0] m);
    mode = m;
    visit(0, 0);
  endtask

  // Drive (x,y), check the address one clk later, then keep the raster moving
  // with (x+1,y) and check pixel/window one further clk later.
  task automatic probe(input bit sel, input int x, input int y, input int exp_addr,
                       input bit chk_addr, input bit exp_win, input string tag);
    int a, p, w;
    pos_x = 10'(x);
    pos_y = 9'(y);
    @(negedge clk);
    a = sel ? int'(mem_addr2) : int'(mem_addr1);
    if (chk_addr) chk({tag, " addr"}, a, exp_addr);
    pos_x = 10'(x + 1);
    @(negedge clk);
    p = sel ? int'(pixel_out2) : int'(pixel_out1);
    w = sel ? int'(in_window2) : int'(in_window1);
    chk({tag, " pixel"}, p, exp_win ? int'(pix_fn(exp_addr)) : 0);
    chk({tag, " in_window"}, w, int'(exp_win));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #30;
    chk("reset mem_addr", int'(mem_addr1), 0);
    chk("reset pixel_out", int'(pixel_out1), 0);
    chk("reset in_window", int'(in_window1), 0);
    chk("reset frame_start", int'(frame_start1), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1x defaults
    new_frame(2'd0);
    lines(1, 2);
    sweep(2, 1, 4);
    probe(0, 5, 2, 357, 1, 1, "1x (5,2)");
    lines(3, 143);
    sweep(143, 1, 174);
    probe(0, 175, 143, 25343, 1, 1, "1x last pixel");
    probe(0, 177, 143, 25343, 1, 0, "1x right border");

    // 2x
    new_frame(2'd1);
    lines(1, 2);
    sweep(2, 1, 4);
    probe(0, 5, 2, 178, 1, 1, "2x (5,2)");
    lines(3, 287);
    sweep(287, 1, 350);
    probe(0, 351, 287, 25343, 1, 1, "2x last pixel");
    new_frame(2'd1);
    sweep(0, 1, 351);
    probe(0, 352, 0, 175, 1, 0, "2x (352,0) border");

    // 4x, clipped to the screen
    new_frame(2'd2);
    lines(1, 479);
    sweep(479, 1, 638);
    probe(0, 639, 479, 21103, 1, 1, "4x (639,479)");
    new_frame(2'd2);
    sweep(0, 1, 639);
    probe(0, 640, 0, 159, 1, 0, "4x (640,0) border");

    // reserved mode behaves as 1x
    new_frame(2'd3);
    lines(1, 2);
    sweep(2, 1, 4);
    probe(0, 5, 2, 357, 1, 1, "mode3 (5,2)");

    // mid-frame mode change waits for the next (0,0)
    new_frame(2'd0);
    lines(1, 50);
    sweep(50, 1, 99);
    mode = 2'd1;
    probe(0, 100, 50, 8900, 1, 1, "mode change mid-frame");
    visit(0, 0);
    chk("frame_start pulse", int'(frame_start1), 1);
    visit(0, 1);
    chk("frame_start drop", int'(frame_start1), 0);
    visit(0, 2);
    sweep(2, 1, 4);
    probe(0, 5, 2, 178, 1, 1, "mode change next frame");

    // offset window (64,16), 1x
    new_frame(2'd0);
    lines(1, 16);
    sweep(16, 1, 63);
    probe(1, 64, 16, 0, 1, 1, "ofs (64,16)");
    lines(17, 159);
    sweep(159, 1, 238);
    probe(1, 239, 159, 25343, 1, 1, "ofs (239,159)");
    new_frame(2'd0);
    lines(1, 16);
    sweep(16, 1, 62);
    probe(1, 63, 16, 25343, 1, 0, "ofs (63,16) border");
    lines(17, 159);
    sweep(159, 1, 239);
    probe(1, 240, 159, 25343, 1, 0, "ofs (240,159) border");

    // asynchronous reset mid-frame
    new_frame(2'd0);
    lines(1, 100);
    sweep(100, 1, 199);
    pos_x = 10'd200;
    pos_y = 9'd100;
    #2 rst = 1'b0;
    #1;
    chk("async rst mem_addr", int'(mem_addr1), 0);
    chk("async rst pixel_out", int'(pixel_out1), 0);
    chk("async rst in_window", int'(in_window1), 0);
    chk("async rst frame_start", int'(frame_start1), 0);
    pos_x = '0;
    pos_y = '0;
    repeat (3) @(negedge clk);
    chk("held rst mem_addr", int'(mem_addr1), 0);
    chk("held rst frame_start", int'(frame_start1), 0);
    rst = 1'b1;
    new_frame(2'd0);
    lines(1, 2);
    sweep(2, 1, 4);
    probe(0, 5, 2, 357, 1, 1, "after rst (5,2)");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
